// File: rtl/simon_session_ctrl.sv
// Session controller for the Simon core: start/abort sequencing, press strobes,
// round scoring, high score and a timed game-over display before returning to idle.
module simon_session_ctrl #(
  parameter int HOLD_TICKS = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [3:0] btn_i,
  input  logic       simon_turn_i,
  input  logic       simon_game_over_i,
  output logic       simon_reset_o,
  output logic [1:0] player_num_o,
  output logic       player_pressed_o,
  output logic [4:0] score_o,
  output logic [4:0] high_score_o,
  output logic       win_o,
  output logic [1:0] state_o
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [4:0]    score_q, score_d;
  logic [4:0]    high_q, high_d;
  logic          win_q, win_d;
  logic          start_q;
  logic          turn_q, turn_d;
  logic          btn_lock_q, btn_lock_d;
  logic          simon_reset_q, simon_reset_d;
  logic          pressed_q, pressed_d;
  logic [1:0]    num_q, num_d;

  logic          start_rise;
  logic          turn_rise;
  logic [4:0]    score_inc;
  logic          onehot;
  logic [1:0]    btn_idx;
  logic          accept;

  assign start_rise = start_i & ~start_q;
  assign turn_rise  = simon_turn_i & ~turn_q;
  assign score_inc  = (turn_rise && (score_q != 5'd16)) ? score_q + 5'd1 : score_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      score_q       <= 5'd0;
      high_q        <= 5'd0;
      win_q         <= 1'b0;
      start_q       <= 1'b1;
      turn_q        <= 1'b1;
      btn_lock_q    <= 1'b1;
      simon_reset_q <= 1'b1;
      pressed_q     <= 1'b0;
      num_q         <= 2'd0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      score_q       <= score_d;
      high_q        <= high_d;
      win_q         <= win_d;
      start_q       <= start_i;
      turn_q        <= turn_d;
      btn_lock_q    <= btn_lock_d;
      simon_reset_q <= simon_reset_d;
      pressed_q     <= pressed_d;
      num_q         <= num_d;
    end
  end

  // Forcing turn_q high on start keeps a turn flag already up from counting as a round.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    score_d = score_q;
    high_d  = high_q;
    win_d   = win_q;
    turn_d  = simon_turn_i;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = PLAY;
          score_d = 5'd0;
          turn_d  = 1'b1;
        end
      end
      PLAY: begin
        score_d = score_inc;
        if (simon_game_over_i) begin
          state_d = OVER;
          hold_d  = '0;
          if (score_inc > high_q) high_d = score_inc;
          win_d   = (score_inc == 5'd16);
        end else if (start_rise) begin
          state_d = IDLE;
        end
      end
      OVER: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
          win_d   = 1'b0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    onehot  = 1'b1;
    btn_idx = 2'd0;
    case (btn_i)
      4'b0001: btn_idx = 2'd0;
      4'b0010: btn_idx = 2'd1;
      4'b0100: btn_idx = 2'd2;
      4'b1000: btn_idx = 2'd3;
      default: onehot  = 1'b0;
    endcase
    accept = (state_q == PLAY) && !simon_turn_i && !simon_game_over_i && !btn_lock_q && onehot;
    pressed_d     = accept;
    num_d         = accept ? btn_idx : num_q;
    // Any nonzero pattern locks, so chords burn the press until all buttons are released.
    btn_lock_d    = |btn_i;
    simon_reset_d = (state_d == IDLE);
  end

  assign simon_reset_o    = simon_reset_q;
  assign player_num_o     = num_q;
  assign player_pressed_o = pressed_q;
  assign score_o          = score_q;
  assign high_score_o     = high_q;
  assign win_o            = win_q;
  assign state_o          = state_q;

endmodule

// File: doc/simon_session_ctrl.md
# simon_session_ctrl

Session controller that sequences the Simon game core. It parks the core in reset until the player presses start and converts the four raw colour buttons into single-cycle `player_num`/`player_pressed` strobes. It counts completed rounds, keeps a high score, and holds the game-over/win result for a fixed display time before returning to idle. It sits between the board buttons and the Simon core, and also drives the score display.

## Interface
- `HOLD_TICKS`, default 180: cycles spent in OVER before returning to IDLE (3 s at 60 Hz).
- `clk` in 1: game clock, 60 Hz.
- `reset` in 1: synchronous, active-high.
- `start` in 1: start button, synchronized level.
- `btn` in 4: colour buttons, synchronized levels; bit i means colour i.
- `simon_turn` in 1: Simon core turn flag (1 = Simon playing the sequence).
- `simon_game_over` in 1: Simon core game-over flag.
- `simon_reset` out 1: reset to the Simon core.
- `player_num` out 2: encoded colour of the accepted press.
- `player_pressed` out 1: one-cycle strobe for an accepted press.
- `score` out 5: rounds completed in the current game, 0..16.
- `high_score` out 5: best `score` since reset.
- `win` out 1: final game ended with all 16 rounds completed.
- `state` out 2: IDLE=0, PLAY=1, OVER=2.

Clock is `clk`. Reset is `reset`, synchronous and active-high. All outputs are registered.

## Operation
- **Reset values:** state IDLE, `simon_reset`=1, `player_num`=0, `player_pressed`=0, `score`=0, `high_score`=0, `win`=0. Internal `start_q`=1, `turn_q`=1, `btn_lock`=1, hold counter 0.
- **IDLE**
  - `simon_reset`=1.
  - On a rising `start` edge (`start`=1, `start_q`=0): go to PLAY, clear `score`, set `turn_q`=1.
- **PLAY**
  - `simon_reset`=0.
  - **Round count:** a rising `simon_turn` edge (`simon_turn`=1, `turn_q`=0) increments `score`, saturating at 16.
  - **Game over:** `simon_game_over`=1 moves to OVER.
    - `score` takes its incremented value if a turn edge occurs in the same cycle.
    - `high_score` is updated to that final score if it is greater.
    - `win` is set when the final score is 16.
  - **Abort:** a rising `start` edge goes to IDLE; `high_score` is not updated. Game over takes priority over abort in the same cycle.
- **OVER**
  - `simon_reset`=0, so the core keeps reporting game over.
  - Hold counter counts 0..HOLD_TICKS-1. When it reaches HOLD_TICKS-1, go to IDLE, clear `win` and clear the counter.
  - `start` is ignored in OVER. `score` stays frozen through OVER and IDLE until the next start.
- **Press acceptance**, evaluated every cycle. A press is accepted only when all of these hold:
  - state is PLAY;
  - `simon_turn`=0;
  - `simon_game_over`=0;
  - `btn_lock`=0;
  - exactly one bit of `btn` is set.
- **On acceptance:** `player_pressed`=1 for one cycle, `player_num` = index of the set bit, `btn_lock`=1.
- **Lock rule:**
  - `btn_lock` clears only after a cycle with `btn`=0.
  - Any nonzero `btn` while unlocked also sets `btn_lock`. Chords (2+ bits) are therefore discarded entirely and never produce a strobe.
- `player_num` holds its last value between strobes.
- `start_q` and `turn_q` are updated every cycle in all states.

## Timing
- **Press:** `btn` rises at edge N → `player_pressed`=1 after edge N+1, low after N+2. Latency 1 cycle.
- **Start:** `start` rises → `state`=PLAY and `simon_reset`=0 one cycle later.
- **Score:** `simon_turn` rises → `score` increments one cycle later.
- **Game over:** `simon_game_over` rises → `state`=OVER and `high_score`/`win` valid one cycle later.
- **OVER duration:** exactly HOLD_TICKS cycles, then IDLE.
- **Reset mid-game:** returns to IDLE next edge with all reset values. `high_score` is lost.
- **Start held from before IDLE entry:** does not restart; a 0 then 1 is required.
- **Button held across the IDLE→PLAY transition:** produces no strobe until released and pressed again, because `btn_lock` was set while the button was held.

## Test plan
- **Start:** reset, then pulse `start` → `simon_reset` 1→0 and `state`=1 one cycle after the edge; holding `start` high for 100 cycles causes no abort.
- **Single press:** PLAY with `simon_turn`=0, `btn`=4'b0100 held 10 cycles → exactly one `player_pressed` pulse with `player_num`=2; after release, `btn`=4'b0001 → pulse with `player_num`=0.
- **Chord and Simon turn:**
  - `btn`=4'b0110 → no strobe.
  - Release, then `btn`=4'b1000 with `simon_turn`=1 → no strobe.
  - Same press after `simon_turn`=0 → strobe only after release and re-press.
- **Scoring:** 5 `simon_turn` rising edges, then `simon_game_over`=1 → `score`=5, `high_score`=5, `win`=0, `state`=2 for 180 cycles, then 0. Next game ending at `score`=3 leaves `high_score`=5.
- **Win:** 15 turn edges, then a turn edge coincident with `simon_game_over` → `score`=16, `win`=1, `high_score`=16.
- **Abort/reset:**
  - `start` edge in PLAY at `score`=4 → IDLE, `high_score` unchanged.
  - `reset` asserted in OVER → all outputs at reset values next cycle.
